spu_ifetch_queue: RTL and testbench
===================================

// Module: spu_ifetch_queue
// PURPOSE
//  Parametrised instruction fetch/queue unit for the SPU-Lite core. Fetches aligned groups of
//  FETCH_W instructions from the local-store read port, buffers them in a DEPTH-entry circular
//  queue with per-entry PC, and presents up to FETCH_W in-order instructions per cycle to the
//  dual-issue decode stage. Handles branch redirect (flush + refetch) and misaligned targets.
// PARAMETERS
//  INST_LEN  32  instruction width in bits
//  ADDR_W    11  local-store word-address width (PC is a word address)
//  FETCH_W   2   instructions per fetch group and max instructions dequeued per cycle (power of 2)
//  DEPTH     8   queue entries (power of 2, DEPTH >= 2*FETCH_W)
// PORTS
//  clk          in   1                  clock, all state updates on rising edge
//  reset        in   1                  synchronous, active-high reset
//  start        in   1                  pulse: begin fetching at start_pc
//  start_pc     in   ADDR_W             initial fetch PC
//  mem_rd_en    out  1                  local-store read request
//  mem_rd_addr  out  ADDR_W             group-aligned read address (low log2(FETCH_W) bits zero)
//  mem_rd_data  in   FETCH_W*INST_LEN   read data, valid exactly 1 cycle after mem_rd_en; slot 0 in LSBs
//  br_valid     in   1                  branch redirect from execute
//  br_target    in   ADDR_W             redirect PC (any alignment)
//  out_valid    out  FETCH_W            thermometer: out_valid[i] => slot i holds a valid instruction
//  out_inst     out  FETCH_W*INST_LEN   head instructions, slot 0 = oldest
//  out_pc       out  FETCH_W*ADDR_W     PC of each output slot
//  deq_cnt      in   $clog2(FETCH_W+1)  instructions consumed this cycle (0..FETCH_W)
//  q_count      out  $clog2(DEPTH+1)    current queue occupancy
// BEHAVIOUR
//  - Reset: FSM=IDLE; queue empty; rd/wr pointers 0; fetch_pc 0; in-flight flag 0; epoch 0;
//    mem_rd_en=0, mem_rd_addr=0, out_valid=0, out_inst=0, out_pc=0, q_count=0. Reset mid-run
//    drops everything, including a response arriving the next cycle.
//  - FSM: IDLE -start-> RUN (fetch_pc<=start_pc). RUN -br_valid-> RUN with flush. start in RUN is ignored.
//  - Fetch (RUN only): mem_rd_en=1 iff free slots minus in-flight reservation >= FETCH_W and no
//    br_valid this cycle. mem_rd_addr = fetch_pc with low bits cleared; fetch_pc advances to the
//    next aligned group. At most one request in flight; latency 1 cycle, so back-to-back requests allowed.
//  - Response: captured the cycle after mem_rd_en, tagged with the epoch current at issue. Slots
//    below (req_pc mod FETCH_W) are dropped (misaligned entry only on first group after start/redirect);
//    remaining slots written in order with PC = group base + slot index.
//  - Redirect: br_valid flushes queue (count<=0, ptrs reset), toggles epoch so any in-flight
//    response is discarded, sets fetch_pc<=br_target. First new request issues the following cycle.
//  - Dequeue: removes min(deq_cnt, number of valid head slots) entries; excess deq_cnt is clamped,
//    never underflows. Simultaneous br_valid and deq_cnt: redirect wins, deq ignored. Simultaneous
//    enqueue and dequeue in one cycle: count = count + written - removed.
//  - Outputs are registered views of the head: out_valid[i]=1 iff q_count > i (after update);
//    invalid slots drive inst=0, pc=0. Pointers wrap modulo DEPTH; PC wraps modulo 2^ADDR_W.
//  - Queue never overflows: reservation rule guarantees space for every accepted response.
// TESTING
//  1. reset, start_pc=0x000, deq_cnt=0 -> reads at 0x000,0x002,0x004,0x006 then mem_rd_en=0; q_count=8, out_pc={1,0}.
//  2. start_pc=0x005 -> first read addr 0x004; only inst@0x005 enqueued; out_valid=2'b01 until next group, then head pcs 0x005,0x006.
//  3. queue full, deq_cnt=2 each cycle -> steady state one read per cycle, q_count stable, PCs strictly sequential.
//  4. br_valid (target 0x100) the cycle after a read of 0x010 -> 0x010 data discarded; next cycle q_count=0, read addr 0x100.
//  5. br_valid with deq_cnt=2 same cycle, q_count=6 -> q_count=0 next cycle, no underflow; deq_cnt=2 with one valid -> q_count=0.
//  6. reset asserted while a read is in flight -> next cycle all outputs zero, returned data never enqueued; fetch_pc=0x7FE wraps to 0x000.

Source files
------------

// File: rtl/spu_ifetch_queue.sv
// Instruction fetch queue: fetches aligned FETCH_W groups from local store into a DEPTH-entry ring and
// presents the oldest FETCH_W entries with PCs each cycle; fetch stalls whenever a group might not fit.
module spu_ifetch_queue #(
  parameter int INST_LEN = 32,
  parameter int ADDR_W   = 11,
  parameter int FETCH_W  = 2,
  parameter int DEPTH    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            start_pc,
  output logic                         mem_rd_en,
  output logic [ADDR_W-1:0]            mem_rd_addr,
  input  logic [FETCH_W*INST_LEN-1:0]  mem_rd_data,
  input  logic                         br_valid,
  input  logic [ADDR_W-1:0]            br_target,
  output logic [FETCH_W-1:0]           out_valid,
  output logic [FETCH_W*INST_LEN-1:0]  out_inst,
  output logic [FETCH_W*ADDR_W-1:0]    out_pc,
  input  logic [$clog2(FETCH_W+1)-1:0] deq_cnt,
  output logic [$clog2(DEPTH+1)-1:0]   q_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(FETCH_W - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;
  state_t state_q, state_d;

  logic [INST_LEN-1:0]         inst_q [DEPTH];
  logic [INST_LEN-1:0]         inst_d [DEPTH];
  logic [ADDR_W-1:0]           pc_q [DEPTH];
  logic [ADDR_W-1:0]           pc_d [DEPTH];
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [ADDR_W-1:0]           fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
  logic                        inflight_q, inflight_d;
  logic                        req_epoch_q, req_epoch_d, epoch_q, epoch_d;
  logic [FETCH_W-1:0]          out_valid_q, out_valid_d;
  logic [FETCH_W*INST_LEN-1:0] out_inst_q, out_inst_d;
  logic [FETCH_W*ADDR_W-1:0]   out_pc_q, out_pc_d;

  logic                        fetch_go;
  logic [ADDR_W-1:0]           fetch_base, req_base, req_off;
  logic [CNT_W-1:0]            n_wr, n_rm, deq_ext;
  logic [PTR_W-1:0]            widx, ridx;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE && start) state_d = S_RUN;
  end

  // Reserve a full group for the in-flight response so an accepted read can never overflow.
  always_comb begin
    fetch_base = fetch_pc_q & ~LOW_MASK;
    fetch_go   = 1'b0;
    if (!reset && state_q == S_RUN && !br_valid)
      fetch_go = (int'(count_q) + (inflight_q ? FETCH_W : 0) + FETCH_W) <= DEPTH;
    mem_rd_en   = fetch_go;
    mem_rd_addr = fetch_go ? fetch_base : '0;
  end

  always_comb begin
    inst_d      = inst_q;
    pc_d        = pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    req_epoch_d = req_epoch_q;
    epoch_d     = epoch_q;
    inflight_d  = fetch_go;
    req_base    = req_pc_q & ~LOW_MASK;
    req_off     = req_pc_q & LOW_MASK;
    deq_ext     = CNT_W'(deq_cnt);
    n_wr        = '0;
    n_rm        = '0;
    widx        = '0;

    if (state_q == S_IDLE) begin
      if (start) fetch_pc_d = start_pc;
    end else if (br_valid) begin
      epoch_d    = ~epoch_q;
      fetch_pc_d = br_target;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (fetch_go) begin
        req_pc_d    = fetch_pc_q;
        req_epoch_d = epoch_q;
        fetch_pc_d  = fetch_base + ADDR_W'(FETCH_W);
      end
      // Slots ahead of a misaligned target are skipped; the rest pack in at the tail.
      if (inflight_q && req_epoch_q == epoch_q) begin
        for (int i = 0; i < FETCH_W; i++) begin
          if (ADDR_W'(i) >= req_off) begin
            widx         = wr_ptr_q + PTR_W'(ADDR_W'(i) - req_off);
            inst_d[widx] = mem_rd_data[i*INST_LEN +: INST_LEN];
            pc_d[widx]   = req_base + ADDR_W'(i);
          end
        end
        n_wr = CNT_W'(ADDR_W'(FETCH_W) - req_off);
      end
      n_rm     = (deq_ext < count_q) ? deq_ext : count_q;
      rd_ptr_d = rd_ptr_q + PTR_W'(n_rm);
      wr_ptr_d = wr_ptr_q + PTR_W'(n_wr);
      count_d  = count_q + n_wr - n_rm;
    end
  end

  always_comb begin
    out_valid_d = '0;
    out_inst_d  = '0;
    out_pc_d    = '0;
    ridx        = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      if (count_d > CNT_W'(i)) begin
        ridx                                = rd_ptr_d + PTR_W'(i);
        out_valid_d[i]                      = 1'b1;
        out_inst_d[i*INST_LEN +: INST_LEN]  = inst_d[ridx];
        out_pc_d[i*ADDR_W +: ADDR_W]        = pc_d[ridx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fetch_pc_q  <= '0;
      req_pc_q    <= '0;
      inflight_q  <= 1'b0;
      req_epoch_q <= 1'b0;
      epoch_q     <= 1'b0;
      out_valid_q <= '0;
      out_inst_q  <= '0;
      out_pc_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      inflight_q  <= inflight_d;
      req_epoch_q <= req_epoch_d;
      epoch_q     <= epoch_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
    end
  end

  // Entry storage is qualified by count/pointers, so it needs no reset.
  always_ff @(posedge clk) begin
    inst_q <= inst_d;
    pc_q   <= pc_d;
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_pc    = out_pc_q;
  assign q_count   = count_q;

endmodule

// File: tb/tb_spu_ifetch_queue.sv
// Bench for spu_ifetch_queue: read addresses and dequeued instructions are scoreboarded by a
// negedge monitor; occupancy and head views are checked at directed points.
module tb_spu_ifetch_queue;
  localparam int INST_LEN = 32;
  localparam int ADDR_W   = 11;
  localparam int FETCH_W  = 2;
  localparam int DEPTH    = 8;

  logic                         clk = 1'b0;
  logic                         reset, start, br_valid;
  logic [ADDR_W-1:0]            start_pc, br_target;
  logic                         mem_rd_en;
  logic [ADDR_W-1:0]            mem_rd_addr;
  logic [FETCH_W*INST_LEN-1:0]  mem_rd_data;
  logic [FETCH_W-1:0]           out_valid;
  logic [FETCH_W*INST_LEN-1:0]  out_inst;
  logic [FETCH_W*ADDR_W-1:0]    out_pc;
  logic [$clog2(FETCH_W+1)-1:0] deq_cnt;
  logic [$clog2(DEPTH+1)-1:0]   q_count;

  always #5 clk = ~clk;

  spu_ifetch_queue #(.INST_LEN(INST_LEN), .ADDR_W(ADDR_W), .FETCH_W(FETCH_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .br_valid(br_valid), .br_target(br_target),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .deq_cnt(deq_cnt), .q_count(q_count)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [ADDR_W-1:0] exp_addr[$];
  logic [ADDR_W-1:0] exp_pc[$];

  function automatic logic [31:0] inst_of(input logic [ADDR_W-1:0] pc);
    return 32'hC0DE_0000 | {21'h0, pc};
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    cmp({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
    cmp({tag, "_rd_addr"}, 64'(mem_rd_addr), 64'd0);
    cmp({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    cmp({tag, "_out_inst"}, 64'(out_inst), 64'd0);
    cmp({tag, "_out_pc"}, 64'(out_pc), 64'd0);
    cmp({tag, "_q_count"}, 64'(q_count), 64'd0);
  endtask

  // Local-store model: answers one cycle after each request; junk otherwise.
  initial begin : mem_model
    logic              pend;
    logic [ADDR_W-1:0] paddr;
    mem_rd_data = '0;
    forever begin
      @(negedge clk);
      pend  = mem_rd_en;
      paddr = mem_rd_addr;
      @(posedge clk);
      #1;
      for (int i = 0; i < FETCH_W; i++)
        mem_rd_data[i*INST_LEN +: INST_LEN] = pend ? inst_of(paddr + ADDR_W'(i)) : 32'hBAD0_0000 | 32'(i);
    end
  end

  initial begin : monitor
    logic [ADDR_W-1:0] e;
    forever begin
      @(negedge clk);
      if (mem_rd_en) begin
        if (exp_addr.size() == 0) cmp("rd_unexpected", 64'(mem_rd_addr), 64'h1_0000);
        else begin
          e = exp_addr.pop_front();
          cmp("rd_addr", 64'(mem_rd_addr), 64'(e));
        end
      end
      if (!reset && !br_valid) begin
        for (int i = 0; i < FETCH_W; i++) begin
          if (i < int'(deq_cnt) && out_valid[i]) begin
            if (exp_pc.size() == 0) cmp("deq_unexpected", 64'(out_pc[i*ADDR_W +: ADDR_W]), 64'h1_0000);
            else begin
              e = exp_pc.pop_front();
              cmp("deq_pc", 64'(out_pc[i*ADDR_W +: ADDR_W]), 64'(e));
              cmp("deq_inst", 64'(out_inst[i*INST_LEN +: INST_LEN]), 64'(inst_of(e)));
            end
          end
        end
      end
    end
  end

  initial begin : stim
    reset = 1'b1; start = 1'b0; start_pc = '0; br_valid = 1'b0; br_target = '0; deq_cnt = '0;
    cyc(); cyc();
    @(negedge clk);
    check_idle("reset");

    // Fill from 0x000 with no consumer: exactly four reads, then full.
    cyc(); reset = 1'b0; start = 1'b1; start_pc = 11'h000;
    exp_addr.push_back(11'h000); exp_addr.push_back(11'h002);
    exp_addr.push_back(11'h004); exp_addr.push_back(11'h006);
    cyc(); start = 1'b0;
    repeat (6) cyc();
    start = 1'b1; start_pc = 11'h300;
    @(negedge clk);
    cmp("fill_q_count", 64'(q_count), 64'd8);
    cmp("fill_out_valid", 64'(out_valid), 64'b11);
    cmp("fill_out_pc", 64'(out_pc), 64'({11'h001, 11'h000}));
    cmp("fill_out_inst", 64'(out_inst), {inst_of(11'h001), inst_of(11'h000)});

    // Steady drain of two per cycle.
    cyc(); start = 1'b0; deq_cnt = 2'd2;
    for (int p = 0; p < 12; p++) exp_pc.push_back(ADDR_W'(p));
    exp_addr.push_back(11'h008); exp_addr.push_back(11'h00A); exp_addr.push_back(11'h00C);
    exp_addr.push_back(11'h00E); exp_addr.push_back(11'h010);
    for (int k = 2; k <= 6; k++) begin
      cyc();
      if (k >= 4) begin
        @(negedge clk);
        cmp("steady_q_count", 64'(q_count), 64'd4);
      end
    end

    // Redirect while the 0x010 response is returning.
    cyc(); deq_cnt = '0; br_valid = 1'b1; br_target = 11'h100;
    @(negedge clk);
    cmp("pre_br_q_count", 64'(q_count), 64'd4);
    exp_addr.push_back(11'h100); exp_addr.push_back(11'h102);
    exp_addr.push_back(11'h104); exp_addr.push_back(11'h106);
    cyc(); br_valid = 1'b0;
    @(negedge clk);
    cmp("br_q_count", 64'(q_count), 64'd0);
    cmp("br_out_valid", 64'(out_valid), 64'd0);
    cmp("br_out_pc", 64'(out_pc), 64'd0);
    cyc(); cyc(); cyc();

    // Redirect to a misaligned target with a simultaneous dequeue, then over-dequeue.
    cyc(); br_valid = 1'b1; br_target = 11'h201; deq_cnt = 2'd2;
    @(negedge clk);
    cmp("brdeq_pre_q_count", 64'(q_count), 64'd6);
    exp_addr.push_back(11'h200); exp_addr.push_back(11'h202); exp_addr.push_back(11'h204);
    exp_addr.push_back(11'h206); exp_addr.push_back(11'h208);
    cyc(); br_valid = 1'b0; deq_cnt = '0;
    @(negedge clk);
    cmp("brdeq_q_count", 64'(q_count), 64'd0);
    cyc();
    cyc(); deq_cnt = 2'd2; exp_pc.push_back(11'h201);
    @(negedge clk);
    cmp("mis_q_count", 64'(q_count), 64'd1);
    cmp("mis_out_valid", 64'(out_valid), 64'b01);
    cmp("mis_out_pc", 64'(out_pc), 64'({11'h000, 11'h201}));
    cyc(); deq_cnt = '0;
    @(negedge clk);
    cmp("clamp_q_count", 64'(q_count), 64'd2);
    cmp("clamp_out_pc", 64'(out_pc), 64'({11'h203, 11'h202}));
    repeat (4) cyc();

    // Misaligned start at 0x005.
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0; start = 1'b1; start_pc = 11'h005;
    exp_addr.push_back(11'h004); exp_addr.push_back(11'h006);
    exp_addr.push_back(11'h008); exp_addr.push_back(11'h00A);
    cyc(); start = 1'b0;
    cyc();
    cyc();
    @(negedge clk);
    cmp("start5_q_count", 64'(q_count), 64'd1);
    cmp("start5_out_valid", 64'(out_valid), 64'b01);
    cmp("start5_out_pc", 64'(out_pc), 64'({11'h000, 11'h005}));
    cmp("start5_out_inst", 64'(out_inst), {32'h0, inst_of(11'h005)});
    cyc();
    @(negedge clk);
    cmp("start5_next_valid", 64'(out_valid), 64'b11);
    cmp("start5_next_pc", 64'(out_pc), 64'({11'h006, 11'h005}));
    repeat (4) cyc();

    // PC wrap at the top of local store, then reset with a response returning.
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0; start = 1'b1; start_pc = 11'h7FE;
    exp_addr.push_back(11'h7FE); exp_addr.push_back(11'h000);
    cyc(); start = 1'b0;
    cyc();
    cyc(); reset = 1'b1;
    @(negedge clk);
    cmp("wrap_q_count", 64'(q_count), 64'd2);
    cmp("wrap_out_pc", 64'(out_pc), 64'({11'h7FF, 11'h7FE}));
    cmp("wrap_out_inst", 64'(out_inst), {inst_of(11'h7FF), inst_of(11'h7FE)});
    cyc(); reset = 1'b0;
    @(negedge clk);
    check_idle("midrst");
    repeat (3) cyc();
    @(negedge clk);
    check_idle("post_rst");

    cmp("rd_queue_drained", 64'(exp_addr.size()), 64'd0);
    cmp("deq_queue_drained", 64'(exp_pc.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
